// File: rtl/sprite_anim_gen_pkg.sv
// Shared types and screen defaults for the sprite animation generator.
// The screen constants are also used by the VGA sync generator.
package sprite_anim_gen_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_TICK_LINE = 481;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_BOUNCE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_UPDATE = 1'b1
  } state_e;

endpackage

// File: rtl/sprite_anim_gen_axis_mover.sv
// One-axis next-position logic: clamped manual step or bouncing step.
// dir_i = 1 means moving towards LIMIT, 0 towards zero.
module sprite_anim_gen_axis_mover
  import sprite_anim_gen_pkg::*;
#(
  parameter int W     = 10,
  parameter int LIMIT = 600,
  parameter int VEL   = 5
) (
  input  logic [W-1:0] pos_i,
  input  logic         dir_i,
  input  logic         inc_req_i,
  input  logic         dec_req_i,
  input  logic         bounce_en_i,
  output logic [W-1:0] pos_next_o,
  output logic         dir_next_o,
  output logic         reflect_o
);

  localparam int AW = W + 1;

  logic [AW-1:0] pos_w;
  logic [AW-1:0] up_w;
  logic [AW-1:0] dn_w;
  logic [AW-1:0] lim_w;
  logic [AW-1:0] pos_n;
  logic          dn_ok;
  logic          up_over;

  // One spare bit so pos+VEL cannot wrap before the limit compare.
  assign pos_w   = {1'b0, pos_i};
  assign lim_w   = AW'(LIMIT);
  assign up_w    = pos_w + AW'(VEL);
  assign dn_w    = pos_w - AW'(VEL);
  assign dn_ok   = pos_w >= AW'(VEL);
  assign up_over = up_w > lim_w;

  always_comb begin
    pos_n      = pos_w;
    dir_next_o = dir_i;
    reflect_o  = 1'b0;
    if (bounce_en_i) begin
      if (dir_i) begin
        if (up_over) begin
          pos_n      = lim_w;
          dir_next_o = 1'b0;
          reflect_o  = 1'b1;
        end else begin
          pos_n = up_w;
        end
      end else begin
        if (!dn_ok) begin
          pos_n      = '0;
          dir_next_o = 1'b1;
          reflect_o  = 1'b1;
        end else begin
          pos_n = dn_w;
        end
      end
    end else if (inc_req_i) begin
      pos_n = up_over ? lim_w : up_w;
    end else if (dec_req_i) begin
      pos_n = dn_ok ? dn_w : '0;
    end
  end

  assign pos_next_o = pos_n[W-1:0];

endmodule

// File: rtl/sprite_anim_gen.sv
// Square sprite over a background colour, moved once per frame either
// by push buttons or by bouncing off the screen walls.
module sprite_anim_gen #(
  parameter int H_ACTIVE  = sprite_anim_gen_pkg::DEF_H_ACTIVE,
  parameter int V_ACTIVE  = sprite_anim_gen_pkg::DEF_V_ACTIVE,
  parameter int COORD_W   = 10,
  parameter int SIZE      = 40,
  parameter int VEL       = 5,
  parameter int RGB_W     = 3,
  parameter logic [RGB_W-1:0] BG_COLOR = 'b110,
  parameter int TICK_LINE = sprite_anim_gen_pkg::DEF_TICK_LINE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         push,
  input  logic               mode,
  input  logic               pause,
  input  logic [RGB_W-1:0]   obj_color,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               video_on,
  output logic [RGB_W-1:0]   rgb,
  output logic               frame_tick,
  output logic               hit
);

  import sprite_anim_gen_pkg::*;

  localparam int CW   = COORD_W + 1;
  localparam int XMAX = H_ACTIVE - SIZE;
  localparam int YMAX = V_ACTIVE - SIZE;

  state_e state_q, state_d;

  logic               cond, cond_q;
  logic [COORD_W-1:0] x_q, x_d, x_nx;
  logic [COORD_W-1:0] y_q, y_d, y_nx;
  logic               dx_q, dx_d, dx_nx;
  logic               dy_q, dy_d, dy_nx;
  logic               rx, ry;
  logic               hit_q, hit_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               bounce;
  logic               inc_x, dec_x, inc_y, dec_y;
  logic [CW-1:0]      x_end, y_end;
  logic               in_x, in_y;

  assign cond       = (pixel_y == COORD_W'(TICK_LINE)) && (pixel_x == '0);
  assign frame_tick = cond & ~cond_q;
  assign bounce     = mode_e'(mode) == MODE_BOUNCE;

  // Manual moves touch one axis only: right > left > down > up.
  assign inc_x = push[0];
  assign dec_x = ~push[0] & push[1];
  assign inc_y = ~|push[1:0] & push[2];
  assign dec_y = ~|push[2:0] & push[3];

  sprite_anim_gen_axis_mover #(
    .W(COORD_W), .LIMIT(XMAX), .VEL(VEL)
  ) u_ax_x (
    .pos_i(x_q), .dir_i(dx_q),
    .inc_req_i(inc_x), .dec_req_i(dec_x),
    .bounce_en_i(bounce),
    .pos_next_o(x_nx), .dir_next_o(dx_nx),
    .reflect_o(rx)
  );

  sprite_anim_gen_axis_mover #(
    .W(COORD_W), .LIMIT(YMAX), .VEL(VEL)
  ) u_ax_y (
    .pos_i(y_q), .dir_i(dy_q),
    .inc_req_i(inc_y), .dec_req_i(dec_y),
    .bounce_en_i(bounce),
    .pos_next_o(y_nx), .dir_next_o(dy_nx),
    .reflect_o(ry)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    hit_d   = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        if (frame_tick) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_d = ST_WAIT;
        if (!pause) begin
          x_d   = x_nx;
          y_d   = y_nx;
          dx_d  = dx_nx;
          dy_d  = dy_nx;
          hit_d = rx | ry;
        end
      end
    endcase
  end

  assign x_end = {1'b0, x_q} + CW'(SIZE - 1);
  assign y_end = {1'b0, y_q} + CW'(SIZE - 1);
  assign in_x  = (pixel_x >= x_q) && ({1'b0, pixel_x} <= x_end);
  assign in_y  = (pixel_y >= y_q) && ({1'b0, pixel_y} <= y_end);

  always_comb begin
    rgb_d = '0;
    if (video_on) rgb_d = (in_x && in_y) ? obj_color : BG_COLOR;
  end

  // cond_q resets high so no tick can escape while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
      cond_q  <= 1'b1;
      x_q     <= COORD_W'(XMAX / 2);
      y_q     <= COORD_W'(YMAX / 2);
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      hit_q   <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      hit_q   <= hit_d;
      rgb_q   <= rgb_d;
    end
  end

  assign rgb = rgb_q;
  assign hit = hit_q;

endmodule

// File: tb/tb_sprite_anim_gen.sv
// Directed and random frames against a plain-arithmetic sprite model.
// Velocity 2 lets the sprite land exactly on 598/438 next to the walls.
module tb_sprite_anim_gen;

  localparam int V    = 2;
  localparam int SZ   = 40;
  localparam int XMAX = 640 - SZ;
  localparam int YMAX = 480 - SZ;
  localparam int TL   = 481;
  localparam logic [2:0] BG = 3'b110;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] push;
  logic       mode;
  logic       pause;
  logic [2:0] obj_color;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic [2:0] rgb;
  logic       frame_tick;
  logic       hit;

  int n_chk  = 0;
  int n_fail = 0;
  int mx, my, mdx, mdy;

  always #5 clk = ~clk;

  sprite_anim_gen #(.VEL(V)) dut (
    .clk(clk), .rst(rst), .push(push), .mode(mode),
    .pause(pause), .obj_color(obj_color),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .rgb(rgb),
    .frame_tick(frame_tick), .hit(hit)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 300; my = 220; mdx = 1; mdy = 1;
  endtask

  task automatic model_step(input logic [3:0] p, input logic m,
                            input logic pz, output logic h);
    int nx, ny;
    h = 1'b0;
    if (pz) return;
    if (!m) begin
      if (p[0])      mx = (mx + V > XMAX) ? XMAX : mx + V;
      else if (p[1]) mx = (mx - V < 0) ? 0 : mx - V;
      else if (p[2]) my = (my + V > YMAX) ? YMAX : my + V;
      else if (p[3]) my = (my - V < 0) ? 0 : my - V;
    end else begin
      nx = mx + mdx * V;
      ny = my + mdy * V;
      if (nx > XMAX)   begin mx = XMAX; mdx = -1; h = 1'b1; end
      else if (nx < 0) begin mx = 0;    mdx = 1;  h = 1'b1; end
      else mx = nx;
      if (ny > YMAX)   begin my = YMAX; mdy = -1; h = 1'b1; end
      else if (ny < 0) begin my = 0;    mdy = 1;  h = 1'b1; end
      else my = ny;
    end
  endtask

  // Tick condition held 3 clocks; one tick pulse, hit 2 clocks later.
  task automatic frame(input logic [3:0] p, input logic m,
                       input logic pz);
    logic [5:0] tm, hm;
    logic eh;
    push = p; mode = m; pause = pz;
    model_step(p, m, pz, eh);
    tm = '0; hm = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pixel_y = (i < 3) ? 10'(TL) : 10'd0;
      pixel_x = (i < 3) ? 10'd0 : 10'd1;
      #1;
      tm[i] = frame_tick;
      hm[i] = hit;
    end
    chk("frame_tick", 32'(tm), 32'h01);
    chk("hit", 32'(hm), eh ? 32'h04 : 32'h00);
  endtask

  task automatic probe(input int px, input int py, input logic vo,
                       input string tag);
    logic [9:0] qx, qy;
    logic [2:0] exp;
    qx = px[9:0];
    qy = py[9:0];
    @(negedge clk);
    pixel_x = qx; pixel_y = qy; video_on = vo;
    @(negedge clk);
    if (!vo) exp = 3'd0;
    else if (int'(qx) >= mx && int'(qx) <= mx + SZ - 1 &&
             int'(qy) >= my && int'(qy) <= my + SZ - 1)
      exp = obj_color;
    else exp = BG;
    chk(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic check_pos();
    obj_color = 3'($urandom_range(1, 7));
    probe(mx,          my,          1'b1, "pix_tl");
    probe(mx - 1,      my,          1'b1, "pix_left");
    probe(mx,          my - 1,      1'b1, "pix_above");
    probe(mx + SZ - 1, my + SZ - 1, 1'b1, "pix_br");
    probe(mx + SZ,     my + SZ - 1, 1'b1, "pix_right");
    probe(mx + SZ - 1, my + SZ,     1'b1, "pix_below");
    probe(mx,          my,          1'b0, "pix_blank");
  endtask

  // Assert reset between edges; outputs must clear with no clock edge.
  task automatic async_reset();
    @(negedge clk);
    pixel_x = 10'(mx); pixel_y = 10'(my); video_on = 1'b1;
    obj_color = 3'd5;
    @(negedge clk);
    chk("pre_rst_rgb", 32'(rgb), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    pixel_x = 10'd0; pixel_y = 10'(TL);
    #1;
    chk("rst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pixel_y = 10'd0; pixel_x = 10'd1;
    model_reset();
  endtask

  initial begin
    logic [3:0] rp;
    rst = 1'b1; push = '0; mode = 1'b0; pause = 1'b0;
    obj_color = 3'd1; pixel_x = 10'd5; pixel_y = 10'd5;
    video_on = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rgb", 32'(rgb), 32'd0);
    chk("reset_hit", 32'(hit), 32'd0);
    chk("reset_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;

    frame(4'b0000, 1'b0, 1'b0);
    check_pos();

    for (int i = 0; i < 10; i++) frame(4'b1001, 1'b0, 1'b0);
    check_pos();
    for (int i = 0; i < 150; i++) begin
      frame(4'b0001, 1'b0, 1'b0);
      check_pos();
    end

    async_reset();
    check_pos();
    for (int i = 0; i < 149; i++) frame(4'b0001, 1'b0, 1'b0);
    check_pos();
    frame(4'b0000, 1'b1, 1'b0);
    check_pos();
    frame(4'b0000, 1'b1, 1'b0);
    check_pos();

    async_reset();
    for (int i = 0; i < 149; i++) frame(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 109; i++) frame(4'b0100, 1'b0, 1'b0);
    check_pos();
    frame(4'b0000, 1'b1, 1'b0);
    check_pos();
    frame(4'b0000, 1'b1, 1'b0);
    check_pos();

    for (int i = 0; i < 3; i++) begin
      frame(4'b0001, 1'b1, 1'b1);
      check_pos();
    end
    async_reset();
    check_pos();

    for (int i = 0; i < 300; i++) begin
      rp = 4'($urandom);
      frame(rp, 1'($urandom), ($urandom_range(0, 7) == 0));
      if (i % 10 == 0) check_pos();
    end
    check_pos();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
